// File: rtl/rca_serial_adder_if.sv
//------------------------------------------------------------------------------
// rca_serial_adder_if
//
// Handshake bundle for the bit-serial ripple-carry adder. The operand side
// (in_valid/in_ready, a, b, cin) and the result side (out_valid/out_ready,
// sum, cout, overflow, busy) travel together so the adder and its neighbours
// connect with a single port.
//
// Modports
//   master : the environment around the adder. It drives the operands and
//            out_ready, and observes the result and status.
//   slave  : the adder itself. It consumes the operands and drives the
//            result and status.
//
// Signals
//   in_valid   operand pair valid
//   in_ready   adder can accept an operand pair
//   a, b       operands, WIDTH bits, unsigned or two's complement
//   cin        carry-in
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of the MSB
//   overflow   signed overflow
//   busy       an operation is in flight or waiting to be taken
//------------------------------------------------------------------------------
interface rca_serial_adder_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  overflow,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output overflow,
    output busy
  );

endinterface : rca_serial_adder_if

// File: rtl/rca_serial_adder.sv
//------------------------------------------------------------------------------
// rca_serial_adder
//
// Bit-serial ripple-carry adder. It captures an operand pair and carry-in
// through a valid/ready handshake and then resolves one full-adder bit per
// clock, LSB first. The finished sum, carry-out and signed overflow are held
// in registers and offered downstream through a second valid/ready handshake.
//
// Parameters
//   WIDTH      operand and sum width in bits (>= 2)
//
// Ports
//   clk        single clock, every state update on the rising edge
//   rst        synchronous, active-high reset
//   bus        rca_serial_adder_if.slave
//                in_valid/in_ready, a, b, cin    operand handshake
//                out_valid/out_ready             result handshake
//                sum, cout, overflow             registered result
//                busy                            high in RUN or DONE
//
// Timing
//   Operands accepted at edge k. Bits 0..WIDTH-1 are resolved at edges
//   k+1..k+WIDTH, so out_valid is high after edge k+WIDTH. The result is
//   taken at the first edge with out_ready high, and the block is back in
//   IDLE after that edge; it never re-accepts in the same cycle, which gives
//   a minimum issue interval of WIDTH+2 cycles.
//------------------------------------------------------------------------------
module rca_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  rca_serial_adder_if.slave  bus
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One full-adder cell built from generate/propagate terms.
  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a_bit,
                                          input logic b_bit,
                                          input logic c_bit);
    logic gen;
    logic prop;
    gen  = a_bit & b_bit;
    prop = a_bit ^ b_bit;
    return {gen | (c_bit & prop), prop ^ c_bit};
  endfunction

  // Control state
  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // Datapath state
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Current bit slice and its full-adder result
  logic             a_bit_d;
  logic             b_bit_d;
  logic [1:0]       fa_d;
  logic             sum_bit_d;
  logic             carry_d;

  always_comb begin
    a_bit_d   = a_q[idx_q];
    b_bit_d   = b_q[idx_q];
    fa_d      = full_add(a_bit_d, b_bit_d, c_q);
    sum_bit_d = fa_d[0];
    carry_d   = fa_d[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        // Wait for an operand pair. The running carry register starts as cin.
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            c_q        <= bus.cin;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        // Resolve one bit per cycle. Bits not yet reached stay 0 in sum_q.
        RUN: begin
          sum_q[idx_q] <= sum_bit_d;
          c_q          <= carry_d;
          if (idx_q == IDX_LAST) begin
            // c_q is the carry into the MSB here; carry_d is the carry out.
            cout_q      <= carry_d;
            ovf_q       <= c_q ^ carry_d;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end

        // Hold the result until it is taken. in_ready only rises after the
        // handshake edge, so a new operand can never be taken in this cycle.
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule : rca_serial_adder

// File: tb/tb_rca_serial_adder.sv
//------------------------------------------------------------------------------
// tb_rca_serial_adder
//
// Bench for rca_serial_adder with WIDTH = 4. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
//------------------------------------------------------------------------------
module tb_rca_serial_adder;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  rca_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  rca_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called and returning at a falling edge. Issues one operation, checks the
  // acceptance-to-result latency and compares {cout, overflow, sum}. With
  // out_ready low the result is left pending in DONE.
  task automatic do_op(input string tag, input logic [3:0] a,
                       input logic [3:0] b, input logic c,
                       input logic [5:0] exp);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.in_ready) begin
      check({tag, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.a        = a;
    bus.b        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    // Scramble the operand inputs: they must be ignored during RUN.
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = a ^ b;
    bus.cin      = ~c;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check({tag, "_result"}, 32'({bus.cout, bus.overflow, bus.sum}), 32'(exp));
  endtask

  initial begin
    logic [4:0] tot;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       ec;
    logic       eovf;
    logic       seen;
    int         i;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{"add_7_8",     4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[1] = '{"add_F_1",     4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[2] = '{"add_F_F_c1",  4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{"add_7_1",     4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[4] = '{"add_8_8",     4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
    vecs[5] = '{"add_5_2_c1",  4'h5, 4'h2, 1'b1, 4'h8, 1'b0, 1'b1};
    vecs[6] = '{"add_0_0_c1",  4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
    vecs[7] = '{"add_A_3",     4'hA, 4'h3, 1'b0, 4'hD, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = 4'h0;
    bus.b         = 4'h0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ctrl", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    check("reset_data", 32'({bus.cout, bus.overflow, bus.sum}), 32'd0);

    // Directed vectors
    for (int k = 0; k < 8; k++) begin
      do_op(vecs[k].name, vecs[k].a, vecs[k].b, vecs[k].cin,
            {vecs[k].cout, vecs[k].ovf, vecs[k].sum});
      check({vecs[k].name, "_busy"}, 32'({bus.busy, bus.in_ready}), 32'b10);
    end
    @(negedge clk);
    check("idle_after_take", 32'({bus.in_ready, bus.out_valid, bus.busy}),
          32'b100);

    // Backpressure: result held while out_ready is low, in_valid ignored
    bus.out_ready = 1'b0;
    do_op("bp_op", 4'h7, 4'h1, 1'b0, {1'b0, 1'b1, 4'h8});
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = 4'h3;
      bus.b        = 4'h3;
      bus.cin      = 1'b1;
      @(negedge clk);
      check("bp_hold", 32'({bus.in_ready, bus.out_valid, bus.busy,
                            bus.cout, bus.overflow, bus.sum}),
            32'({3'b011, 1'b0, 1'b1, 4'h8}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    @(negedge clk);
    check("bp_no_ghost_op", 32'({bus.in_ready, bus.busy}), 32'b10);

    // Reset during the second RUN cycle discards the operation
    bus.a        = 4'hF;
    bus.b        = 4'h1;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ctrl", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
    check("rst_mid_sum", 32'({bus.cout, bus.overflow, bus.sum}), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_mid_no_result", 32'(seen), 32'd0);
    do_op("after_rst", 4'h2, 4'h3, 1'b0, {1'b0, 1'b0, 4'h5});

    // Exhaustive, back-to-back with out_ready high; reference uses sign bits
    for (i = 0; i < 512; i++) begin
      ea   = i[3:0];
      eb   = i[7:4];
      ec   = i[8];
      tot  = 5'(ea) + 5'(eb) + 5'(ec);
      eovf = (ea[3] == eb[3]) && (tot[3] != ea[3]);
      do_op("exh", ea, eb, ec, {tot[4], eovf, tot[3:0]});
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rca_serial_adder
